serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
- Serial bit-pattern transmitter: the driving end of the single-bit `x` stream consumed by the `detector` (1101 sequence detector).
- Accepts parallel words over a valid/ready handshake and shifts them out MSB-first, one bit per clock, with a programmable idle gap after each word.
- Runs a built-in overlapping-1101 reference model that produces the expected `z` per cycle and a match count, so benches and self-test logic can check the detector against it.

Parameters:
- WIDTH, 16, bits per parallel word (>=4).
- CNT_W, 16, width of the saturating match counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  word to transmit; bit WIDTH-1 is sent first.
- din_valid  in  1  din is presented.
- din_ready  out  1  block accepts din this cycle; transfer happens when din_valid & din_ready at an edge.
- gap_len  in  4  number of idle cycles after the word; sampled at accept.
- clr_cnt  in  1  synchronous clear of match_cnt.
- x  out  1  serial bit (registered); forced 0 when not valid.
- x_valid  out  1  x carries a data bit this cycle.
- z_exp  out  1  expected detector output, aligned with x.
- match_cnt  out  CNT_W  number of z_exp pulses, saturating.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; x, x_valid, z_exp, match_cnt, shift register, history all 0.
  - din_ready is gated low while rst=1.
  - A word in progress is discarded; no partial bits after reset.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - din_ready=1.
  - On accept: x<=din[WIDTH-1], x_valid<=1, shreg<=din<<1, bcnt<=WIDTH-1, gcnt<=gap_len, go to SHIFT.
  - First bit is visible the cycle after the accept edge.
- SHIFT:
  - While bcnt!=0, each edge: x<=shreg[MSB], shift left, bcnt--.
  - x_valid stays high for exactly WIDTH consecutive cycles per word.
  - In the cycle showing the last bit (bcnt==0):
    - If gcnt==0: din_ready=1. An accept loads the next word with no bubble (continuous stream). With no accept, go to IDLE, x<=0, x_valid<=0.
    - If gcnt!=0: din_ready=0; go to GAP, x<=0, x_valid<=0.
- GAP:
  - x=0, x_valid=0; gcnt decrements each edge.
  - din_ready=1 only when gcnt==1; an accept there starts the next word, so exactly gap_len invalid cycles separate the words.
  - With no accept at gcnt==1, go to IDLE.
- gap_len and din are sampled only at accept; changes at other times have no effect.
- Reference model:
  - 3-bit history register hist shifts in the value of x every cycle, including the 0s driven during GAP and IDLE, mirroring what the detector samples.
  - z_exp is registered together with x: z_exp<=(hist_next_prev==3'b110) & x_next. It is high in the same cycle x shows the final 1 of 1101.
  - Overlap is allowed: 1101101 gives two pulses.
- match_cnt:
  - +1 on each cycle that z_exp is set; holds at 2^CNT_W-1.
  - clr_cnt has priority over the increment: a simultaneous clear and match gives 0.
- busy=1 in SHIFT and GAP.

Test Plan:
1. Hold rst 3 cycles -> x, x_valid, z_exp, match_cnt = 0 and din_ready=0 throughout; din_ready=1 the first cycle after release.
2. din=16'hD000, gap_len=0 -> x sequence 1,1,0,1,0×12 over 16 x_valid cycles; z_exp high only on the 4th; match_cnt=1; busy drops after the 16th bit.
3. din=16'hDB6D (overlapping) -> z_exp pulses on bits 4, 7, 10, 13, 16; match_cnt=5.
4. Back-to-back, gap_len=0, A=16'h0006 then B=16'h8000 held valid -> x_valid continuous for 32 cycles; din_ready pulses on A's last bit; z_exp=1 on B's first bit (boundary 1101); match_cnt=1. Repeat with gap_len=2 -> x_valid low exactly 2 cycles; no match; match_cnt unchanged.
5. CNT_W=4, stream 0xDB6D words until 16 matches -> match_cnt holds 15. clr_cnt asserted in a z_exp cycle -> match_cnt=0.
6. rst pulsed during bit 5 of 16'hDDDD -> x_valid=0 the next cycle; hist cleared; a following 16'h0D00 yields exactly 1 z_exp and match_cnt=1.

Source files
------------

// File: rtl/serial_pattern_tx.sv
// Serial bit-pattern transmitter: shifts parallel words out MSB-first
// with a programmable idle gap, plus an overlapping-1101 reference model.
module serial_pattern_tx #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [3:0]       gap_len,
    input  logic             clr_cnt,
    output logic             x,
    output logic             x_valid,
    output logic             z_exp,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             z_q, z_d;
    logic [2:0]       hist_q, hist_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    always_comb begin
        din_ready = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE:    din_ready = 1'b1;
                SHIFT:   din_ready = (bcnt_q == '0) && (gcnt_q == 4'd0);
                GAP:     din_ready = (gcnt_q == 4'd1);
                default: din_ready = 1'b0;
            endcase
        end
    end

    assign accept = din_valid & din_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bcnt_d  = bcnt_q;
        gcnt_d  = gcnt_q;
        x_d     = 1'b0;
        xv_d    = 1'b0;
        unique case (state_q)
            IDLE: state_d = IDLE;
            SHIFT: begin
                if (bcnt_q != '0) begin
                    x_d     = shreg_q[WIDTH-1];
                    xv_d    = 1'b1;
                    shreg_d = shreg_q << 1;
                    bcnt_d  = bcnt_q - BW'(1);
                end else if (gcnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                end
            end
            GAP: begin
                gcnt_d = gcnt_q - 4'd1;
                if (gcnt_q <= 4'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A load overrides whatever the current state would do next
        if (accept) begin
            state_d = SHIFT;
            x_d     = din[WIDTH-1];
            xv_d    = 1'b1;
            shreg_d = din << 1;
            bcnt_d  = BW'(WIDTH - 1);
            gcnt_d  = gap_len;
        end
    end

    // hist holds the last three x values, so z_exp lines up with the final 1
    assign z_d    = (hist_q == 3'b110) & x_d;
    assign hist_d = {hist_q[1:0], x_d};

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt)
            cnt_d = '0;
        else if (z_q && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            x_q     <= 1'b0;
            xv_q    <= 1'b0;
            z_q     <= 1'b0;
            hist_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bcnt_q  <= bcnt_d;
            gcnt_q  <= gcnt_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            z_q     <= z_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
        end
    end

    assign x         = x_q;
    assign x_valid   = xv_q;
    assign z_exp     = z_q;
    assign match_cnt = cnt_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: framing, gaps, 1101 reference
// model, saturating counter and mid-word reset.
module tb_serial_pattern_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic [3:0]  gap_len;
    logic        clr_cnt;

    logic        din_ready, x, x_valid, z_exp, busy;
    logic [15:0] match_cnt;
    logic        din_ready4, x4, x_valid4, z_exp4, busy4;
    logic [3:0]  match_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_pattern_tx #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .gap_len(gap_len), .clr_cnt(clr_cnt),
        .x(x), .x_valid(x_valid), .z_exp(z_exp),
        .match_cnt(match_cnt), .busy(busy)
    );

    serial_pattern_tx #(.WIDTH(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready4), .gap_len(gap_len), .clr_cnt(clr_cnt),
        .x(x4), .x_valid(x_valid4), .z_exp(z_exp4),
        .match_cnt(match_cnt4), .busy(busy4)
    );

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Present w until accepted (bounded), then record all 16 bit cycles.
    task automatic run_word(input logic [15:0] w, input logic [3:0] g,
                            output logic [15:0] xs, output logic [15:0] vs,
                            output logic [15:0] zs);
        int n;
        xs = '0; vs = '0; zs = '0;
        @(negedge clk);
        din = w; gap_len = g; din_valid = 1'b1;
        n = 0;
        while (!din_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!din_ready) begin
            errors++;
            $display("FAIL accept_timeout: din_ready=%b required 1", din_ready);
        end
        @(posedge clk);
        #1 din_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            xs[15-i] = x;
            vs[15-i] = x_valid;
            zs[15-i] = z_exp;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; din = '0; din_valid = 1'b0; gap_len = '0; clr_cnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({x, x_valid, z_exp, din_ready, busy} !== 5'b0 ||
                match_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: x=%b v=%b z=%b rdy=%b busy=%b cnt=%0d required all 0",
                         i, x, x_valid, z_exp, din_ready, busy, match_cnt);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (din_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1", din_ready);
        end
    endtask

    task automatic test_single;
        logic [15:0] xs, vs, zs;
        run_word(16'hD000, 4'd0, xs, vs, zs);
        checks++;
        if (xs !== 16'hD000 || vs !== 16'hFFFF) begin
            errors++;
            $display("FAIL single_bits: x=%h valid=%h required D000 FFFF", xs, vs);
        end
        checks++;
        if (zs !== 16'h1000) begin
            errors++;
            $display("FAIL single_z: got %h required 1000", zs);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || x_valid !== 1'b0 || match_cnt !== 16'd1) begin
            errors++;
            $display("FAIL single_after: busy=%b v=%b cnt=%0d required 0 0 1",
                     busy, x_valid, match_cnt);
        end
        idle(3);
    endtask

    task automatic test_overlap;
        logic [15:0] xs, vs, zs;
        run_word(16'hDB6D, 4'd0, xs, vs, zs);
        checks++;
        if (xs !== 16'hDB6D || zs !== 16'h1249) begin
            errors++;
            $display("FAIL overlap_z: x=%h z=%h required DB6D 1249", xs, zs);
        end
        @(negedge clk);
        checks++;
        if (match_cnt !== 16'd6) begin
            errors++;
            $display("FAIL overlap_cnt: got %0d required 6", match_cnt);
        end
        idle(3);
    endtask

    task automatic test_back_to_back;
        logic [31:0] xs, vs, zs, rs;
        logic [33:0] gx, gv, gz, gr;
        logic [15:0] base;
        base = match_cnt;
        @(negedge clk);
        din = 16'h0006; gap_len = 4'd0; din_valid = 1'b1;
        @(posedge clk);
        #1 din = 16'h8000;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            xs[31-i] = x; vs[31-i] = x_valid;
            zs[31-i] = z_exp; rs[31-i] = din_ready;
            if (i == 16) din_valid = 1'b0;
        end
        din_valid = 1'b0;
        checks++;
        if (vs !== 32'hFFFF_FFFF || xs !== 32'h0006_8000) begin
            errors++;
            $display("FAIL b2b_stream: v=%h x=%h required FFFFFFFF 00068000", vs, xs);
        end
        checks++;
        if (rs !== 32'h0001_0001) begin
            errors++;
            $display("FAIL b2b_ready: got %h required 00010001", rs);
        end
        checks++;
        if (zs !== 32'h0000_8000) begin
            errors++;
            $display("FAIL b2b_z: got %h required 00008000", zs);
        end
        idle(2);
        checks++;
        if (match_cnt !== base + 16'd1) begin
            errors++;
            $display("FAIL b2b_cnt: got %0d required %0d", match_cnt, base + 16'd1);
        end
        idle(3);
        base = match_cnt;
        @(negedge clk);
        din = 16'h0006; gap_len = 4'd2; din_valid = 1'b1;
        @(posedge clk);
        #1 din = 16'h8000; gap_len = 4'd0;
        for (int i = 0; i < 34; i++) begin
            @(negedge clk);
            gx[33-i] = x; gv[33-i] = x_valid;
            gz[33-i] = z_exp; gr[33-i] = din_ready;
            if (i == 18) din_valid = 1'b0;
        end
        din_valid = 1'b0;
        checks++;
        if (gv !== {16'hFFFF, 2'b00, 16'hFFFF} || gx !== {16'h0006, 2'b00, 16'h8000}) begin
            errors++;
            $display("FAIL gap_stream: v=%h x=%h", gv, gx);
        end
        checks++;
        if (gr !== (34'h1 | (34'h1 << 16)) || gz !== 34'h0) begin
            errors++;
            $display("FAIL gap_ready_z: rdy=%h z=%h required 10001 0", gr, gz);
        end
        idle(2);
        checks++;
        if (match_cnt !== base) begin
            errors++;
            $display("FAIL gap_cnt: got %0d required %0d", match_cnt, base);
        end
        idle(3);
    endtask

    task automatic test_saturate_clear;
        int acc, n;
        logic [15:0] xs, vs, zs;
        @(negedge clk);
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        din = 16'hDB6D; gap_len = 4'd0; din_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            if (din_ready) begin
                acc++;
                if (acc == 4) begin
                    @(posedge clk);
                    #1 din_valid = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        din_valid = 1'b0;
        idle(20);
        checks++;
        if (match_cnt4 !== 4'd15) begin
            errors++;
            $display("FAIL sat_cnt4: got %0d required 15", match_cnt4);
        end
        checks++;
        if (match_cnt !== 16'd20) begin
            errors++;
            $display("FAIL sat_cnt16: got %0d required 20", match_cnt);
        end
        @(negedge clk);
        din = 16'hDB6D; din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!z_exp && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!z_exp) begin
            errors++;
            $display("FAIL clr_wait: z_exp=%b required 1", z_exp);
        end
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (match_cnt !== 16'd0 || match_cnt4 !== 4'd0) begin
            errors++;
            $display("FAIL clr_priority: cnt=%0d cnt4=%0d required 0 0",
                     match_cnt, match_cnt4);
        end
        clr_cnt = 1'b0;
        idle(25);
    endtask

    task automatic test_mid_reset;
        logic [15:0] xs, vs, zs;
        logic        z4;
        @(negedge clk);
        din = 16'hDDDD; gap_len = 4'd0; din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        z4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 3) z4 = z_exp;
        end
        rst = 1'b1;
        checks++;
        if (z4 !== 1'b1 || x !== 1'b1 || x_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: z4=%b x=%b v=%b required 1 1 1", z4, x, x_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (x_valid !== 1'b0 || x !== 1'b0 || busy !== 1'b0 || match_cnt !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: v=%b x=%b busy=%b cnt=%0d required 0 0 0 0",
                     x_valid, x, busy, match_cnt);
        end
        idle(2);
        checks++;
        if (x_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_partial: v=%b required 0", x_valid);
        end
        run_word(16'h0D00, 4'd0, xs, vs, zs);
        checks++;
        if (xs !== 16'h0D00 || zs !== 16'h0100) begin
            errors++;
            $display("FAIL post_reset_z: x=%h z=%h required 0D00 0100", xs, zs);
        end
        idle(2);
        checks++;
        if (match_cnt !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_cnt: got %0d required 1", match_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overlap();
        test_back_to_back();
        test_saturate_clear();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
